// File: rtl/lsu_ecc_scrub_ctl.sv
// ---------------------------------------------------------------------------
// lsu_ecc_scrub_ctl
//
// Writes single-bit-corrected DCCM words back to memory. When the DC3 ECC
// decoders flag a correctable error on a load, the corrected lo/hi bank
// words are captured into a small pending queue. The DCCM write port is
// shared between these scrub writes and store-buffer drains. The store
// buffer is forced through after STARVE_MAX consecutive denials.
//
// Ports:
//   clk, rst                   core clock, asynchronous active-high reset
//   lsu_pkt_valid_dc3          valid load in DC3
//   flush_dc3                  DC3 instruction killed, no capture
//   dec_tlu_core_ecc_disable   suppress all captures
//   single_ecc_error_lo/hi_dc3 correctable error on lo / hi bank
//   lsu_double_ecc_error_dc3   uncorrectable error, suppresses capture
//   lsu_addr_dc3, end_addr_dc3 start / end byte address of the load
//   sec_data_lo/hi_dc3         corrected lo / hi bank words
//   dccm_port_busy             DCCM port used by a read this cycle
//   stbuf_wr_req / _gnt        store buffer drain request / grant
//   scrub_wren/_addr/_data     scrub write to DCCM (word aligned)
//   lsu_ecc_stall              queue nearly full, block new DCCM loads
//   ecc_overflow               one-cycle pulse when a capture was dropped
//   drop_cnt                   saturating count of dropped captures
// ---------------------------------------------------------------------------
module lsu_ecc_scrub_ctl #(
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_pkt_valid_dc3,
    input  logic              flush_dc3,
    input  logic              dec_tlu_core_ecc_disable,
    input  logic              single_ecc_error_lo_dc3,
    input  logic              single_ecc_error_hi_dc3,
    input  logic              lsu_double_ecc_error_dc3,
    input  logic [ADDR_W-1:0] lsu_addr_dc3,
    input  logic [ADDR_W-1:0] end_addr_dc3,
    input  logic [DATA_W-1:0] sec_data_lo_dc3,
    input  logic [DATA_W-1:0] sec_data_hi_dc3,
    input  logic              dccm_port_busy,
    input  logic              stbuf_wr_req,
    output logic              stbuf_wr_gnt,
    output logic              scrub_wren,
    output logic [ADDR_W-1:0] scrub_wr_addr,
    output logic [DATA_W-1:0] scrub_wr_data,
    output logic              lsu_ecc_stall,
    output logic              ecc_overflow,
    output logic [7:0]        drop_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_LVL = CNT_W'(DEPTH - 1);
    localparam logic [STV_W-1:0] STARVE_C  = STV_W'(STARVE_MAX);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t state_reg, state_next;

    // Pending queue storage
    logic [ADDR_W-1:0] addr_reg [DEPTH];
    logic [DATA_W-1:0] data_reg [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [PTR_W-1:0]  wr_ptr_next;

    logic [STV_W-1:0]  starve_reg;
    logic [7:0]        drop_cnt_reg;
    logic              ovf_reg;
    logic              stall_reg;

    // Capture decode
    logic              cap;
    logic              lo_req, hi_req, any_req;
    logic [ADDR_W-1:0] lo_addr, hi_addr;
    logic              lo_match, hi_match, hi_same_lo;
    logic              lo_alloc, hi_alloc;
    logic [CNT_W-1:0]  need, free_slots;
    logic              drop, do_cap;
    logic [PTR_W-1:0]  hi_new_ptr;

    logic [DEPTH-1:0]  slot_live, lo_hit, hi_hit, lo_tgt, hi_tgt;

    // Port arbitration
    logic              force_stbuf;
    logic              gnt_int, wren_int;
    logic              pop;

    assign cap = lsu_pkt_valid_dc3 & ~flush_dc3 & ~dec_tlu_core_ecc_disable
               & ~lsu_double_ecc_error_dc3;

    assign lo_req  = cap & single_ecc_error_lo_dc3;
    assign hi_req  = cap & single_ecc_error_hi_dc3;
    assign any_req = lo_req | hi_req;

    assign lo_addr = {lsu_addr_dc3[ADDR_W-1:2], 2'b00};
    assign hi_addr = {end_addr_dc3[ADDR_W-1:2], 2'b00};

    // Per-slot liveness and address match. The head slot is treated as gone
    // when it is being written out this cycle, so a matching capture takes a
    // fresh slot instead of updating an entry that is about to disappear.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PTR_W-1:0] rel;
            assign rel           = PTR_W'(gi) - rd_ptr_reg;
            assign slot_live[gi] = ({1'b0, rel} < count_reg)
                                 & ~(pop & (rd_ptr_reg == PTR_W'(gi)));
            assign lo_hit[gi]    = slot_live[gi] & (addr_reg[gi] == lo_addr);
            assign hi_hit[gi]    = slot_live[gi] & (addr_reg[gi] == hi_addr);
            assign lo_tgt[gi]    = lo_match ? lo_hit[gi]
                                            : (wr_ptr_reg == PTR_W'(gi));
            // A hi word landing on the same line as the lo word folds into
            // whichever slot the lo word is using.
            assign hi_tgt[gi]    = hi_match   ? hi_hit[gi] :
                                   hi_same_lo ? lo_tgt[gi] :
                                                (hi_new_ptr == PTR_W'(gi));
        end
    endgenerate

    assign lo_match   = |lo_hit;
    assign hi_match   = |hi_hit;
    assign hi_same_lo = lo_req & hi_req & (hi_addr == lo_addr);

    assign lo_alloc   = lo_req & ~lo_match;
    assign hi_alloc   = hi_req & ~hi_match & ~hi_same_lo;
    assign need       = CNT_W'(lo_alloc) + CNT_W'(hi_alloc);

    // Free space ignores a same-cycle pop so the decision is independent of
    // the arbitration path.
    assign free_slots = DEPTH_C - count_reg;
    assign drop       = any_req & (need > free_slots);
    assign do_cap     = any_req & ~drop;
    assign hi_new_ptr = wr_ptr_reg + PTR_W'(lo_alloc);

    assign count_next  = count_reg + (do_cap ? need : '0) - CNT_W'(pop);
    assign wr_ptr_next = wr_ptr_reg + (do_cap ? PTR_W'(need) : '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (count_reg != '0)  state_next = ST_ACTIVE;
            ST_ACTIVE: if (count_next == '0) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs (port arbitration)
    assign force_stbuf = stbuf_wr_req & (starve_reg == STARVE_C);

    always_comb begin
        gnt_int  = 1'b0;
        wren_int = 1'b0;
        case (state_reg)
            ST_IDLE: gnt_int = stbuf_wr_req & ~dccm_port_busy;
            ST_ACTIVE: begin
                if (!dccm_port_busy) begin
                    if (force_stbuf) begin
                        gnt_int = 1'b1;
                    end else if (count_reg != '0) begin
                        wren_int = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs are held low for the whole reset, not just from the next edge.
    assign stbuf_wr_gnt  = gnt_int & ~rst;
    assign scrub_wren    = wren_int & ~rst;
    assign pop           = scrub_wren;
    assign scrub_wr_addr = scrub_wren ? addr_reg[rd_ptr_reg] : '0;
    assign scrub_wr_data = scrub_wren ? data_reg[rd_ptr_reg] : '0;

    // ------------------------------------------------------------------
    // Queue storage and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (do_cap && hi_req && hi_tgt[i]) begin
                    addr_reg[i] <= hi_addr;
                end else if (do_cap && lo_req && lo_tgt[i]) begin
                    addr_reg[i] <= lo_addr;
                end
            end
        end
    end

    // Data needs no reset: a slot is only read while counted as live.
    // When lo and hi share a slot the hi word wins, being the later one.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_cap && hi_req && hi_tgt[i]) begin
                data_reg[i] <= sec_data_hi_dc3;
            end else if (do_cap && lo_req && lo_tgt[i]) begin
                data_reg[i] <= sec_data_lo_dc3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            stall_reg  <= 1'b0;
        end else begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop);
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            // Registered on the next count so the flag tracks occupancy
            // without an extra cycle of lag.
            stall_reg  <= (count_next >= STALL_LVL);
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter, overflow pulse and drop counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_reg <= '0;
        end else if (state_reg == ST_ACTIVE && !dccm_port_busy) begin
            if (force_stbuf) begin
                starve_reg <= '0;
            end else if (scrub_wren && stbuf_wr_req) begin
                starve_reg <= starve_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg      <= 1'b0;
            drop_cnt_reg <= 8'd0;
        end else begin
            ovf_reg <= drop;
            if (drop && drop_cnt_reg != 8'hFF) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end
    end

    assign lsu_ecc_stall = stall_reg;
    assign ecc_overflow  = ovf_reg;
    assign drop_cnt      = drop_cnt_reg;

endmodule

// File: tb/tb_lsu_ecc_scrub_ctl.sv
// ---------------------------------------------------------------------------
// Testbench for lsu_ecc_scrub_ctl: directed scenarios followed by random
// traffic, every cycle compared with a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_lsu_ecc_scrub_ctl;

    localparam int DEPTH      = 4;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              lsu_pkt_valid_dc3;
    logic              flush_dc3;
    logic              dec_tlu_core_ecc_disable;
    logic              single_ecc_error_lo_dc3;
    logic              single_ecc_error_hi_dc3;
    logic              lsu_double_ecc_error_dc3;
    logic [ADDR_W-1:0] lsu_addr_dc3;
    logic [ADDR_W-1:0] end_addr_dc3;
    logic [DATA_W-1:0] sec_data_lo_dc3;
    logic [DATA_W-1:0] sec_data_hi_dc3;
    logic              dccm_port_busy;
    logic              stbuf_wr_req;
    logic              stbuf_wr_gnt;
    logic              scrub_wren;
    logic [ADDR_W-1:0] scrub_wr_addr;
    logic [DATA_W-1:0] scrub_wr_data;
    logic              lsu_ecc_stall;
    logic              ecc_overflow;
    logic [7:0]        drop_cnt;

    always #5 clk = ~clk;

    lsu_ecc_scrub_ctl #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .lsu_pkt_valid_dc3        (lsu_pkt_valid_dc3),
        .flush_dc3                (flush_dc3),
        .dec_tlu_core_ecc_disable (dec_tlu_core_ecc_disable),
        .single_ecc_error_lo_dc3  (single_ecc_error_lo_dc3),
        .single_ecc_error_hi_dc3  (single_ecc_error_hi_dc3),
        .lsu_double_ecc_error_dc3 (lsu_double_ecc_error_dc3),
        .lsu_addr_dc3             (lsu_addr_dc3),
        .end_addr_dc3             (end_addr_dc3),
        .sec_data_lo_dc3          (sec_data_lo_dc3),
        .sec_data_hi_dc3          (sec_data_hi_dc3),
        .dccm_port_busy           (dccm_port_busy),
        .stbuf_wr_req             (stbuf_wr_req),
        .stbuf_wr_gnt             (stbuf_wr_gnt),
        .scrub_wren               (scrub_wren),
        .scrub_wr_addr            (scrub_wr_addr),
        .scrub_wr_data            (scrub_wr_data),
        .lsu_ecc_stall            (lsu_ecc_stall),
        .ecc_overflow             (ecc_overflow),
        .drop_cnt                 (drop_cnt)
    );

    // ------------------------------------------------------------------
    // Reference model: pending writes as a queue of (word address, data)
    // ------------------------------------------------------------------
    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t mq[$];
    bit   m_active;
    int   m_starve;
    int   m_drop;
    bit   m_ovf;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_wren   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_active = 1'b0;
        m_starve = 0;
        m_drop   = 0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_and_check();
        bit                exp_wren, exp_gnt, cap, lo, hi, drop, hi_fold;
        logic [ADDR_W-1:0] la, ha;
        int                lo_idx, hi_idx, first, need, size_before;
        ent_t              nq[$];
        ent_t              e;

        // Expected port owner this cycle
        exp_wren = 1'b0;
        exp_gnt  = 1'b0;
        if (!m_active) begin
            exp_gnt = stbuf_wr_req & ~dccm_port_busy;
        end else if (!dccm_port_busy) begin
            if (stbuf_wr_req && m_starve == STARVE_MAX) exp_gnt = 1'b1;
            else if (mq.size() > 0)                     exp_wren = 1'b1;
        end

        check_val("gnt", stbuf_wr_gnt, exp_gnt);
        check_val("wren", scrub_wren, exp_wren);
        check_val("excl", scrub_wren & stbuf_wr_gnt, 0);
        if (exp_wren) begin
            check_val("wr_addr", scrub_wr_addr, mq[0].a);
            check_val("wr_data", scrub_wr_data, mq[0].d);
        end
        check_val("stall", lsu_ecc_stall, (mq.size() >= DEPTH - 1));
        check_val("overflow", ecc_overflow, m_ovf);
        check_val("drop_cnt", drop_cnt, m_drop);

        if (scrub_wren) begin
            n_wren++;
            $display("scrub write addr=%04h data=%08h t=%0t", scrub_wr_addr, scrub_wr_data, $time);
        end

        // Capture decision
        cap = lsu_pkt_valid_dc3 & ~flush_dc3 & ~dec_tlu_core_ecc_disable
            & ~lsu_double_ecc_error_dc3;
        lo  = cap & single_ecc_error_lo_dc3;
        hi  = cap & single_ecc_error_hi_dc3;
        la  = {lsu_addr_dc3[ADDR_W-1:2], 2'b00};
        ha  = {end_addr_dc3[ADDR_W-1:2], 2'b00};

        lo_idx = -1;
        hi_idx = -1;
        first  = exp_wren ? 1 : 0;
        for (int i = first; i < mq.size(); i++) begin
            if (mq[i].a == la) lo_idx = i;
            if (mq[i].a == ha) hi_idx = i;
        end
        hi_fold = lo && (ha == la);
        need = ((lo && lo_idx < 0) ? 1 : 0) + ((hi && hi_idx < 0 && !hi_fold) ? 1 : 0);
        drop = (lo || hi) && (need > DEPTH - mq.size());

        if (drop) begin
            $display("capture dropped lo=%04h hi=%04h t=%0t", la, ha, $time);
            if (m_drop < 255) m_drop++;
        end else begin
            if (lo) begin
                if (lo_idx >= 0) mq[lo_idx].d = sec_data_lo_dc3;
                else begin
                    e.a = la; e.d = sec_data_lo_dc3;
                    nq.push_back(e);
                end
            end
            if (hi) begin
                if (hi_idx >= 0) mq[hi_idx].d = sec_data_hi_dc3;
                else if (hi_fold) nq[0].d = sec_data_hi_dc3;
                else begin
                    e.a = ha; e.d = sec_data_hi_dc3;
                    nq.push_back(e);
                end
            end
        end

        size_before = mq.size();
        if (exp_wren) void'(mq.pop_front());
        foreach (nq[i]) mq.push_back(nq[i]);

        if (m_active && !dccm_port_busy) begin
            if (stbuf_wr_req && m_starve == STARVE_MAX) m_starve = 0;
            else if (exp_wren && stbuf_wr_req)          m_starve++;
        end
        m_active = m_active ? (mq.size() != 0) : (size_before != 0);
        m_ovf    = drop;
    endtask

    // Inputs are driven at the falling edge; compare shortly after, then
    // advance the model across the rising edge.
    task automatic step();
        #2;
        model_and_check();
        @(negedge clk);
    endtask

    task automatic clear_in();
        lsu_pkt_valid_dc3        = 1'b0;
        flush_dc3                = 1'b0;
        dec_tlu_core_ecc_disable = 1'b0;
        single_ecc_error_lo_dc3  = 1'b0;
        single_ecc_error_hi_dc3  = 1'b0;
        lsu_double_ecc_error_dc3 = 1'b0;
        lsu_addr_dc3             = '0;
        end_addr_dc3             = '0;
        sec_data_lo_dc3          = '0;
        sec_data_hi_dc3          = '0;
    endtask

    task automatic err_evt(input logic elo, input logic ehi,
                           input logic [ADDR_W-1:0] la, input logic [ADDR_W-1:0] ea,
                           input logic [DATA_W-1:0] dlo, input logic [DATA_W-1:0] dhi);
        lsu_pkt_valid_dc3       = 1'b1;
        single_ecc_error_lo_dc3 = elo;
        single_ecc_error_hi_dc3 = ehi;
        lsu_addr_dc3            = la;
        end_addr_dc3            = ea;
        sec_data_lo_dc3         = dlo;
        sec_data_hi_dc3         = dhi;
    endtask

    task automatic idle_steps(input int n);
        clear_in();
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int n0;

        rst = 1'b1;
        clear_in();
        dccm_port_busy = 1'b0;
        stbuf_wr_req   = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_val("rst_wren", scrub_wren, 0);
        check_val("rst_gnt", stbuf_wr_gnt, 0);
        check_val("rst_stall", lsu_ecc_stall, 0);
        check_val("rst_ovf", ecc_overflow, 0);
        check_val("rst_drop", drop_cnt, 0);
        rst = 1'b0;
        idle_steps(2);

        // 1: single lo-bank error
        n0 = n_wren;
        err_evt(1'b1, 1'b0, 16'h0104, 16'h0107, 32'hDEADBEEF, 32'h0);
        step();
        idle_steps(5);
        check_val("t1_writes", n_wren - n0, 1);

        // 2: misaligned load spanning two words, both banks in error
        n0 = n_wren;
        err_evt(1'b1, 1'b1, 16'h0106, 16'h0109, 32'h11111111, 32'h22222222);
        step();
        idle_steps(6);
        check_val("t2_writes", n_wren - n0, 2);

        // 3: four entries against a continuously requesting store buffer
        dccm_port_busy = 1'b1;
        err_evt(1'b1, 1'b1, 16'h0300, 16'h0307, 32'h30000000, 32'h30000004);
        step();
        err_evt(1'b1, 1'b1, 16'h0310, 16'h0317, 32'h30000010, 32'h30000014);
        step();
        idle_steps(1);
        dccm_port_busy = 1'b0;
        stbuf_wr_req   = 1'b1;
        idle_steps(7);
        stbuf_wr_req   = 1'b0;
        idle_steps(3);

        // 4: full queue with the port busy, then one more error
        dccm_port_busy = 1'b1;
        err_evt(1'b1, 1'b1, 16'h0400, 16'h0407, 32'h40000000, 32'h40000004);
        step();
        err_evt(1'b1, 1'b1, 16'h0410, 16'h0417, 32'h40000010, 32'h40000014);
        step();
        err_evt(1'b1, 1'b0, 16'h0420, 16'h0423, 32'h40000020, 32'h0);
        step();
        idle_steps(1);
        check_val("t4_drop", drop_cnt, 1);
        check_val("t4_stall", lsu_ecc_stall, 1);
        dccm_port_busy = 1'b0;
        n0 = n_wren;
        idle_steps(7);
        check_val("t4_writes", n_wren - n0, 4);

        // 5: second error on the same word before it was written
        n0 = n_wren;
        dccm_port_busy = 1'b1;
        err_evt(1'b1, 1'b0, 16'h0200, 16'h0203, 32'hAAAA0001, 32'h0);
        step();
        err_evt(1'b1, 1'b0, 16'h0200, 16'h0203, 32'hBBBB0002, 32'h0);
        step();
        dccm_port_busy = 1'b0;
        idle_steps(5);
        check_val("t5_writes", n_wren - n0, 1);

        // 6a: reset with three entries pending
        dccm_port_busy = 1'b1;
        err_evt(1'b1, 1'b1, 16'h0500, 16'h0507, 32'h50000000, 32'h50000004);
        step();
        err_evt(1'b1, 1'b0, 16'h0510, 16'h0513, 32'h50000010, 32'h0);
        step();
        idle_steps(1);
        check_val("t6_stall_pre", lsu_ecc_stall, 1);
        rst = 1'b1;
        #1;
        check_val("t6_wren", scrub_wren, 0);
        check_val("t6_gnt", stbuf_wr_gnt, 0);
        check_val("t6_stall", lsu_ecc_stall, 0);
        check_val("t6_drop", drop_cnt, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        dccm_port_busy = 1'b0;
        n0 = n_wren;
        idle_steps(6);
        check_val("t6_writes", n_wren - n0, 0);

        // 6b: killed or uncorrectable loads never capture
        n0 = n_wren;
        err_evt(1'b1, 1'b1, 16'h0600, 16'h0607, 32'h60000000, 32'h60000004);
        flush_dc3 = 1'b1;
        step();
        err_evt(1'b1, 1'b1, 16'h0610, 16'h0617, 32'h60000010, 32'h60000014);
        lsu_double_ecc_error_dc3 = 1'b1;
        step();
        err_evt(1'b1, 1'b0, 16'h0620, 16'h0623, 32'h60000020, 32'h0);
        dec_tlu_core_ecc_disable = 1'b1;
        step();
        idle_steps(5);
        check_val("t6b_writes", n_wren - n0, 0);

        // Random traffic over a small address window so coalescing,
        // overflow and starvation all occur.
        for (int c = 0; c < 3000; c++) begin
            logic [ADDR_W-1:0] la;
            clear_in();
            la = 16'h0100 + 16'($urandom_range(0, 31));
            lsu_pkt_valid_dc3        = ($urandom_range(0, 99) < 50);
            flush_dc3                = ($urandom_range(0, 99) < 10);
            lsu_double_ecc_error_dc3 = ($urandom_range(0, 99) < 10);
            dec_tlu_core_ecc_disable = ($urandom_range(0, 99) < 5);
            single_ecc_error_lo_dc3  = ($urandom_range(0, 99) < 40);
            single_ecc_error_hi_dc3  = ($urandom_range(0, 99) < 40);
            lsu_addr_dc3             = la;
            end_addr_dc3             = la + 16'($urandom_range(0, 3));
            sec_data_lo_dc3          = $urandom;
            sec_data_hi_dc3          = $urandom;
            dccm_port_busy           = ($urandom_range(0, 99) < 40);
            stbuf_wr_req             = ($urandom_range(0, 99) < 50);
            step();
        end
        dccm_port_busy = 1'b0;
        stbuf_wr_req   = 1'b0;
        idle_steps(8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
